pll_reconfig_seq: RTL and testbench

//  Table-driven PLL reconfiguration sequencer. It sits between the lag-tester system's

---
 rtl/pll_reconfig_seq_pkg.sv | 56 +++++
 rtl/pll_reconfig_seq_if.sv | 27 ++
 rtl/pll_reconfig_seq_rom.sv | 35 +++
 rtl/pll_reconfig_seq.sv | 167 ++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reconfig_seq_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
//   pll_reg_t    : one Avalon register write (6-bit address, 32-bit data)
//   PLL_REG_*    : pll_cfg register map
//   seq_state_t  : sequencer FSM states
//   MODE_TABLE   : per-mode register write lists, MODE_LEN gives how many are used
package pll_seq_pkg;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } pll_reg_t;

    localparam logic [5:0] PLL_REG_MODE   = 6'h00;
    localparam logic [5:0] PLL_REG_STATUS = 6'h01;
    localparam logic [5:0] PLL_REG_START  = 6'h02;
    localparam logic [5:0] PLL_REG_N      = 6'h03;
    localparam logic [5:0] PLL_REG_M      = 6'h04;
    localparam logic [5:0] PLL_REG_C      = 6'h05;
    localparam logic [5:0] PLL_REG_DPS    = 6'h06;
    localparam logic [5:0] PLL_REG_BW     = 6'h08;
    localparam logic [5:0] PLL_REG_CP     = 6'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_REGS,
        ST_WR_START,
        ST_WAIT_RECFG,
        ST_WAIT_LOCK,
        ST_FINISH
    } seq_state_t;

    localparam int ROM_MODES = 4;
    localparam int ROM_REGS  = 8;

    localparam pll_reg_t REG_NONE = pll_reg_t'{addr: 6'h00, data: 32'h0};

    // Unused tail entries are padding; only the first MODE_LEN[m] are written.
    localparam pll_reg_t MODE_TABLE [ROM_MODES][ROM_REGS] = '{
        '{ pll_reg_t'{PLL_REG_N,  32'h0001_0000}, pll_reg_t'{PLL_REG_M, 32'h0000_0808},
           pll_reg_t'{PLL_REG_C,  32'h0002_0404}, pll_reg_t'{PLL_REG_BW, 32'h0000_0006},
           REG_NONE, REG_NONE, REG_NONE, REG_NONE },
        '{ pll_reg_t'{PLL_REG_M,  32'h0000_0404}, pll_reg_t'{PLL_REG_N, 32'h0001_0000},
           pll_reg_t'{PLL_REG_C,  32'h0002_0302},
           REG_NONE, REG_NONE, REG_NONE, REG_NONE, REG_NONE },
        '{ REG_NONE, REG_NONE, REG_NONE, REG_NONE,
           REG_NONE, REG_NONE, REG_NONE, REG_NONE },
        '{ pll_reg_t'{PLL_REG_N,  32'h0000_0202}, pll_reg_t'{PLL_REG_M, 32'h0000_0A0A},
           pll_reg_t'{PLL_REG_C,  32'h0000_0505}, pll_reg_t'{PLL_REG_C, 32'h0004_0606},
           pll_reg_t'{PLL_REG_DPS, 32'h0000_0001}, pll_reg_t'{PLL_REG_BW, 32'h0000_0007},
           pll_reg_t'{PLL_REG_CP, 32'h0000_0002}, pll_reg_t'{PLL_REG_C, 32'h0008_0808} }
    };

    localparam int MODE_LEN [ROM_MODES] = '{4, 3, 0, 8};

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM write-only management bus towards pll_cfg.
//   mgmt_write       : write strobe (master -> slave)
//   mgmt_address     : register address (master -> slave)
//   mgmt_writedata   : write data (master -> slave)
//   mgmt_waitrequest : stall (slave -> master)
interface pll_reconfig_seq_if;

    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_reconfig_seq_rom.sv
// Combinational mode table lookup.
//   mode  : mode index
//   idx   : entry index within the mode
//   entry : register write at (mode, idx); zero outside the table
//   len   : number of register writes for mode, clamped to NUM_REGS
module pll_mode_rom
    import pll_seq_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int NUM_REGS  = 8,
    localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int IDX_W    = $clog2(NUM_REGS + 1)
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [IDX_W-1:0]  idx,
    output pll_reg_t          entry,
    output logic [IDX_W-1:0]  len
);

    always_comb begin
        entry = '0;
        len   = '0;
        for (int m = 0; m < ROM_MODES; m++) begin
            if (m < NUM_MODES && m == int'(mode)) begin
                len = IDX_W'((MODE_LEN[m] > NUM_REGS) ? NUM_REGS : MODE_LEN[m]);
                for (int r = 0; r < ROM_REGS; r++) begin
                    if (r < NUM_REGS && r == int'(idx)) begin
                        entry = MODE_TABLE[m][r];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Table-driven PLL reconfiguration sequencer on the CLK_50M domain.
// On an accepted req it writes the mode register, the selected mode's register
// list and the start register to pll_cfg, then waits for the reconfig to end and
// the PLL to hold lock for LOCK_STABLE cycles, and reports done/error.
//   clk, reset_n : management clock, asynchronous active-low reset
//   req, mode    : one-cycle request and mode index (latched on accept)
//   busy         : high from accept through the done cycle
//   done, error  : one-cycle completion pulse; error held until next accept
//   mgmt         : Avalon-MM master towards pll_cfg
//   pll_locked   : PLL lock, already synchronised to clk
module pll_reconfig_seq
    import pll_seq_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int NUM_REGS     = 8,
    parameter int LOCK_TIMEOUT = 5_000_000,
    parameter int LOCK_STABLE  = 1024,
    localparam int MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req,
    input  logic [MODE_W-1:0]   mode,
    output logic                busy,
    output logic                done,
    output logic                error,
    pll_reconfig_seq_if.master  mgmt,
    input  logic                pll_locked
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);

    seq_state_t         state;
    logic [MODE_W-1:0]  mode_q;
    logic [IDX_W-1:0]   idx;
    logic [TMO_W-1:0]   tmo;
    logic [STB_W-1:0]   stb;

    pll_reg_t           rom_entry;
    logic [IDX_W-1:0]   rom_len;
    logic [TMO_W-1:0]   tmo_nxt;
    logic [STB_W-1:0]   stb_nxt;
    logic               wr_ok;

    function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [STB_W-1:0] stb_inc(input logic [STB_W-1:0] v);
        return (v == {STB_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    pll_mode_rom #(
        .NUM_MODES (NUM_MODES),
        .NUM_REGS  (NUM_REGS)
    ) u_rom (
        .mode  (mode_q),
        .idx   (idx),
        .entry (rom_entry),
        .len   (rom_len)
    );

    assign tmo_nxt = tmo_inc(tmo);
    assign stb_nxt = stb_inc(stb);
    // Current write is accepted by pll_cfg this cycle.
    assign wr_ok   = ~mgmt.mgmt_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            mode_q              <= '0;
            idx                 <= '0;
            tmo                 <= '0;
            stb                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            mgmt.mgmt_write     <= 1'b0;
            mgmt.mgmt_address   <= '0;
            mgmt.mgmt_writedata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        mode_q <= mode;
                        idx    <= '0;
                        busy   <= 1'b1;
                        error  <= 1'b0;
                        if (int'(mode) >= NUM_MODES) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            mgmt.mgmt_write     <= 1'b1;
                            mgmt.mgmt_address   <= PLL_REG_MODE;
                            mgmt.mgmt_writedata <= '0;
                            state               <= ST_WR_MODE;
                        end
                    end
                end

                // idx counts entries already loaded into the bus registers, so
                // the rom output at idx is always the next write to issue.
                ST_WR_MODE, ST_WR_REGS: begin
                    if (wr_ok) begin
                        if (idx == rom_len) begin
                            mgmt.mgmt_address   <= PLL_REG_START;
                            mgmt.mgmt_writedata <= '0;
                            state               <= ST_WR_START;
                        end else begin
                            mgmt.mgmt_address   <= rom_entry.addr;
                            mgmt.mgmt_writedata <= rom_entry.data;
                            idx                 <= idx + 1'b1;
                            state               <= ST_WR_REGS;
                        end
                    end
                end

                ST_WR_START: begin
                    if (wr_ok) begin
                        mgmt.mgmt_write <= 1'b0;
                        tmo             <= '0;
                        stb             <= '0;
                        state           <= ST_WAIT_RECFG;
                    end
                end

                // pll_cfg holds waitrequest high while it reprograms the PLL.
                ST_WAIT_RECFG: begin
                    tmo <= tmo_nxt;
                    if (tmo_nxt == TMO_W'(LOCK_TIMEOUT)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else if (wr_ok) begin
                        state <= ST_WAIT_LOCK;
                    end
                end

                ST_WAIT_LOCK: begin
                    tmo <= tmo_nxt;
                    stb <= pll_locked ? stb_nxt : '0;
                    if (pll_locked && stb_nxt == STB_W'(LOCK_STABLE)) begin
                        error <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else if (tmo_nxt == TMO_W'(LOCK_TIMEOUT)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq. Main instance uses the default table and
// LOCK_STABLE; a second instance (3 modes, LOCK_TIMEOUT=1000) covers the
// out-of-range mode and the lock timeout.
module tb_pll_reconfig_seq;

    localparam int LS     = 1024;
    localparam int LT_MAIN = 5000;
    localparam int LT_T   = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req, req_t;
    logic [1:0] mode, mode_t;
    logic       busy, done, error;
    logic       busy_t, done_t, error_t;
    logic       pll_locked;

    pll_reconfig_seq_if bus ();
    pll_reconfig_seq_if bus_t ();

    pll_reconfig_seq #(
        .NUM_MODES(4), .NUM_REGS(8), .LOCK_TIMEOUT(LT_MAIN), .LOCK_STABLE(LS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .mode(mode),
        .busy(busy), .done(done), .error(error),
        .mgmt(bus), .pll_locked(pll_locked)
    );

    pll_reconfig_seq #(
        .NUM_MODES(3), .NUM_REGS(8), .LOCK_TIMEOUT(LT_T), .LOCK_STABLE(LS)
    ) dut_t (
        .clk(clk), .reset_n(reset_n), .req(req_t), .mode(mode_t),
        .busy(busy_t), .done(done_t), .error(error_t),
        .mgmt(bus_t), .pll_locked(1'b0)
    );

    assign bus_t.mgmt_waitrequest = 1'b0;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected mode-1 write sequence (address, data).
    logic [37:0] exp1 [0:4] = '{
        {6'h00, 32'h0000_0000}, {6'h04, 32'h0000_0404}, {6'h03, 32'h0001_0000},
        {6'h05, 32'h0002_0302}, {6'h02, 32'h0000_0000}
    };

    // Write log and stall monitor for the main instance, write counter for dut_t.
    logic [37:0] wlog [0:63];
    int          wcount    = 0;
    int          wcount_t  = 0;
    int          stall_cnt = 0;
    int          stall_err = 0;
    bit          prev_stall = 1'b0;
    logic [37:0] prev_word = '0;

    always @(negedge clk) begin
        if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
            if (wcount < 64) wlog[wcount] <= {bus.mgmt_address, bus.mgmt_writedata};
            wcount <= wcount + 1;
        end
        if (prev_stall && !(bus.mgmt_write && {bus.mgmt_address, bus.mgmt_writedata} == prev_word))
            stall_err <= stall_err + 1;
        if (bus.mgmt_write && bus.mgmt_waitrequest) stall_cnt <= stall_cnt + 1;
        prev_stall <= bus.mgmt_write && bus.mgmt_waitrequest;
        prev_word  <= {bus.mgmt_address, bus.mgmt_writedata};
        if (bus_t.mgmt_write && !bus_t.mgmt_waitrequest) wcount_t <= wcount_t + 1;
    end

    // waitrequest driver: 0 = never stall, 1 = 0..5 stall cycles per write.
    int wr_mode = 0;
    initial begin
        int  stall_left;
        bit  in_write;
        stall_left = 0;
        in_write   = 1'b0;
        bus.mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_mode == 0) begin
                bus.mgmt_waitrequest = 1'b0;
                in_write = 1'b0;
            end else begin
                if (bus.mgmt_write && !in_write) begin
                    stall_left = $urandom_range(0, 5);
                    in_write   = 1'b1;
                end
                if (in_write) begin
                    if (stall_left > 0) begin
                        bus.mgmt_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        bus.mgmt_waitrequest = 1'b0;
                        in_write = 1'b0;
                    end
                end else begin
                    bus.mgmt_waitrequest = 1'b0;
                end
            end
        end
    end

    task automatic start_req(input logic [1:0] m);
        @(posedge clk); #1;
        mode = m;
        req  = 1'b1;
        @(posedge clk); #1;
        req  = 1'b0;
    endtask

    task automatic wait_start_main(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mgmt_write && !bus.mgmt_waitrequest && bus.mgmt_address == 6'h02) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_mode1(input string pfx, input int b);
        check_eq({pfx, "_count"}, 64'(wcount - b), 64'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("%s_w%0d", pfx, i), 64'(wlog[b + i]), 64'(exp1[i]));
    endtask

    initial begin
        bit ok;
        int base, snap;
        reset_n    = 1'b0;
        req        = 1'b0;
        mode       = 2'd0;
        req_t      = 1'b0;
        mode_t     = 2'd0;
        pll_locked = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",  64'(busy),  64'd0);
        check_eq("rst_done",  64'(done),  64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_write", 64'(bus.mgmt_write), 64'd0);
        check_eq("rst_addr",  64'(bus.mgmt_address), 64'd0);
        check_eq("rst_data",  64'(bus.mgmt_writedata), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Test 1: mode 1, no stalls, lock rises ~20 cycles after start.
        base = wcount;
        start_req(2'd1);
        @(negedge clk);
        check_eq("t1_first_write", 64'(bus.mgmt_write), 64'd1);
        check_eq("t1_first_addr",  64'(bus.mgmt_address), 64'd0);
        check_eq("t1_busy",        64'(busy), 64'd1);
        wait_start_main(ok);
        check_eq("t1_start_seen", 64'(ok), 64'd1);
        // Second request while busy must be dropped.
        @(posedge clk); #1;
        mode = 2'd0;
        req  = 1'b1;
        @(posedge clk); #1;
        req  = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        pll_locked = 1'b1;
        repeat (LS) @(negedge clk);
        check_eq("t1_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check_eq("t1_done",       64'(done),  64'd1);
        check_eq("t1_error",      64'(error), 64'd0);
        check_eq("t1_busy_done",  64'(busy),  64'd1);
        // Request coincident with FINISH must be dropped.
        req = 1'b1;
        mode = 2'd0;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check_eq("t1_done_pulse", 64'(done), 64'd0);
        check_eq("t1_busy_after", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check_eq("t1_finish_req_busy", 64'(busy), 64'd0);
        check_mode1("t1", base);

        // Test 2: random stalls, lock already high.
        wr_mode = 1;
        base = wcount;
        snap = stall_cnt;
        start_req(2'd1);
        wait_done(3000, ok);
        check_eq("t2_done_seen", 64'(ok), 64'd1);
        check_eq("t2_error",     64'(error), 64'd0);
        check_mode1("t2", base);
        check_eq("t2_stall_stable", 64'(stall_err), 64'd0);
        check_eq("t2_stalls_seen",  64'(stall_cnt > snap), 64'd1);
        wr_mode = 0;
        repeat (3) @(negedge clk);

        // Test 5: one low glitch at stable count 500.
        pll_locked = 1'b0;
        start_req(2'd1);
        wait_start_main(ok);
        check_eq("t5_start_seen", 64'(ok), 64'd1);
        @(posedge clk); #1;
        pll_locked = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        pll_locked = 1'b0;
        @(posedge clk); #1;
        pll_locked = 1'b1;
        repeat (LS) @(negedge clk);
        check_eq("t5_done_early", 64'(done), 64'd0);
        @(negedge clk);
        check_eq("t5_done",  64'(done),  64'd1);
        check_eq("t5_error", 64'(error), 64'd0);
        repeat (3) @(negedge clk);

        // Test 3: out-of-range mode on the 3-mode instance.
        base = wcount_t;
        @(posedge clk); #1;
        mode_t = 2'd3;
        req_t  = 1'b1;
        @(posedge clk); #1;
        req_t  = 1'b0;
        @(negedge clk);
        check_eq("t3_done",  64'(done_t),  64'd1);
        check_eq("t3_error", 64'(error_t), 64'd1);
        check_eq("t3_busy",  64'(busy_t),  64'd1);
        check_eq("t3_write", 64'(bus_t.mgmt_write), 64'd0);
        @(negedge clk);
        check_eq("t3_done_pulse", 64'(done_t),  64'd0);
        check_eq("t3_busy_after", 64'(busy_t),  64'd0);
        check_eq("t3_error_held", 64'(error_t), 64'd1);
        check_eq("t3_no_writes",  64'(wcount_t - base), 64'd0);

        // Test 4: lock never rises, mode 2 (empty list) on the timeout instance.
        base = wcount_t;
        @(posedge clk); #1;
        mode_t = 2'd2;
        req_t  = 1'b1;
        @(posedge clk); #1;
        req_t  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_t.mgmt_write && bus_t.mgmt_address == 6'h02) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("t4_start_seen", 64'(ok), 64'd1);
        repeat (LT_T) @(negedge clk);
        check_eq("t4_done_early", 64'(done_t), 64'd0);
        @(negedge clk);
        check_eq("t4_done",   64'(done_t),  64'd1);
        check_eq("t4_error",  64'(error_t), 64'd1);
        check_eq("t4_writes", 64'(wcount_t - base), 64'd2);

        // Test 6: reset in the middle of the register list, then a clean run.
        pll_locked = 1'b0;
        base = wcount;
        start_req(2'd3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wcount - base >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("t6_regs_reached", 64'(ok), 64'd1);
        check_eq("t6_write_before", 64'(bus.mgmt_write), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_write", 64'(bus.mgmt_write), 64'd0);
        check_eq("t6_rst_busy",  64'(busy), 64'd0);
        check_eq("t6_rst_addr",  64'(bus.mgmt_address), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        snap = wcount;
        repeat (5) @(negedge clk);
        check_eq("t6_no_writes_after_rst", 64'(wcount - snap), 64'd0);
        check_eq("t6_busy_after_rst",      64'(busy), 64'd0);
        pll_locked = 1'b1;
        base = wcount;
        start_req(2'd1);
        wait_done(3000, ok);
        check_eq("t6_done_seen", 64'(ok), 64'd1);
        check_eq("t6_error",     64'(error), 64'd0);
        check_mode1("t6", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
